// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU-side types: data word, RAM handshake states and
//               the memory arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // One machine word on the memory buses.
  typedef logic [31:0] word_t;

  // Handshake state reported by the RAM.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter ownership state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Width of the data-over-instruction starvation counter.
  localparam int unsigned STARVE_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the instruction/data requester ports and the RAM
//               port of the memory arbiter. The slave modport is the arbiter
//               view; the master modport is the view of the surrounding
//               CPU/RAM environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // Requester side
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;

  // RAM side
  ramstate_t ramstate;
  word_t     ramload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;

  // Grant abort pulse
  logic      tmo;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, tmo
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, tmo
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (instruction / data) arbiter in front of a
//               single-ported RAM. Data has priority, bounded by a
//               starvation counter that forces an instruction grant after
//               STARVE_MAX consecutive data grants with iREN pending.
//               RAM outputs are decoded from the registered grant state and
//               the live requester inputs.
//               Optional macro MEM_ARB_TIMEOUT_EN adds a grant watchdog that
//               aborts a grant after TIMEOUT cycles without ACCESS and pulses
//               tmo; without it tmo is tied low and grants wait indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t           state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;

  logic w_dreq;     // data port is requesting (read or write)
  logic w_access;   // RAM reports the access finishing this cycle
  logic w_starve;   // instruction side has waited out its data-grant budget
  logic w_tmo;      // current grant is aborted by the watchdog this cycle

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_access = (bus.ramstate == ACCESS);
  assign w_starve = bus.iREN && (starve_q >= STARVE_LIM);

`ifdef MEM_ARB_TIMEOUT_EN
  // Counter is wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int unsigned  TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             w_owner_req;

  // A withdrawn grant ends through the normal withdrawal path, never as abort.
  assign w_owner_req = ((state_q == DGRANT) && w_dreq) ||
                       ((state_q == IGRANT) && bus.iREN);
  assign w_tmo       = w_owner_req && !w_access && (tmo_cnt_q == TMO_LIM);

  // Watchdog next value: clear when heading to IDLE, count waiting grant cycles.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == IDLE) begin
      tmo_cnt_d = '0;
    end else if ((state_q != IDLE) && !w_access) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo            = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State and starvation counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state: data first unless starving, completion/withdrawal/abort end a grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_dreq && !w_starve) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!w_dreq || w_access || w_tmo) begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!bus.iREN || w_access || w_tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: count data grants taken while iREN waits.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!bus.iREN || (state_d == IGRANT)) begin
        starve_d = '0;
      end else if (state_d == DGRANT) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Output decode from registered state and live inputs; reset forces IDLE values.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.tmo      = 1'b0;
    if (!RST) begin
      case (state_q)
        DGRANT: begin
          bus.ramaddr  = bus.daddr;
          bus.ramREN   = bus.dREN;
          bus.ramWEN   = bus.dWEN;
          bus.ramstore = bus.dstore;
          if (w_dreq && w_access) begin
            bus.dwait = 1'b0;
            if (bus.dREN) begin
              bus.dload = bus.ramload;
            end
          end
        end
        IGRANT: begin
          bus.ramaddr = bus.iaddr;
          bus.ramREN  = 1'b1;
          if (bus.iREN && w_access) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
          end
        end
        default: ;
      endcase
      bus.tmo = w_tmo;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: a cycle-by-cycle vector
//               table plus hand-written starvation and watchdog sequences.
//               Build with MEM_ARB_TIMEOUT_EN to exercise the watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic      rst;
    logic      iren;
    word_t     iaddr;
    logic      dren;
    logic      dwen;
    word_t     daddr;
    word_t     dstore;
    ramstate_t rs;
    word_t     rl;
  } in_t;

  typedef struct packed {
    logic  iwait;
    logic  dwait;
    word_t iload;
    word_t dload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    logic  tmo;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];

  mem_arbiter_if bus();

  mem_arbiter #(
    .TIMEOUT    (8),
    .STARVE_MAX (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t I(logic r, logic ir, word_t ia, logic dr, logic dw,
                            word_t da, word_t ds, ramstate_t s, word_t rl);
    return {r, ir, ia, dr, dw, da, ds, s, rl};
  endfunction

  function automatic out_t O(logic iw, logic dw, word_t il, word_t dl, logic ren,
                             logic wen, word_t a, word_t st, logic t);
    return {iw, dw, il, dl, ren, wen, a, st, t};
  endfunction

  function automatic out_t sample();
    return {bus.iwait, bus.dwait, bus.iload, bus.dload, bus.ramREN, bus.ramWEN,
            bus.ramaddr, bus.ramstore, bus.tmo};
  endfunction

  task automatic apply(input in_t v);
    rst          = v.rst;
    bus.iREN     = v.iren;
    bus.iaddr    = v.iaddr;
    bus.dREN     = v.dren;
    bus.dWEN     = v.dwen;
    bus.daddr    = v.daddr;
    bus.dstore   = v.dstore;
    bus.ramstate = v.rs;
    bus.ramload  = v.rl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    out_t idl;
    out_t act;
    int   dcnt;
    int   icnt;
    word_t ild;
    logic exp_tmo;
    logic exp_ren;

    n_tests = 0;
    n_fail  = 0;
    idl     = O(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- cycle-by-cycle table ----------------
    // reset, then single instruction read with ACCESS two cycles into grant
    tbl.push_back('{I(1, 0, 0,     0, 0, 0, 0, FREE, 0), idl});
    tbl.push_back('{I(1, 1, 32'h40, 0, 0, 0, 0, FREE, 0), idl});
    tbl.push_back('{I(0, 1, 32'h40, 0, 0, 0, 0, FREE, 0), idl});
    tbl.push_back('{I(0, 1, 32'h40, 0, 0, 0, 0, BUSY, 0), O(1, 1, 0, 0, 1, 0, 32'h40, 0, 0)});
    tbl.push_back('{I(0, 1, 32'h40, 0, 0, 0, 0, BUSY, 0), O(1, 1, 0, 0, 1, 0, 32'h40, 0, 0)});
    tbl.push_back('{I(0, 1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C22_0004),
                    O(0, 1, 32'h8C22_0004, 0, 1, 0, 32'h40, 0, 0)});
    tbl.push_back('{I(0, 0, 0, 0, 0, 0, 0, FREE, 0), idl});
    // simultaneous instruction read and data write: data wins, instruction after IDLE
    tbl.push_back('{I(0, 1, 32'h80, 0, 1, 32'h100, 32'hDEAD_BEEF, FREE, 0), idl});
    tbl.push_back('{I(0, 1, 32'h80, 0, 1, 32'h100, 32'hDEAD_BEEF, ACCESS, 32'h55),
                    O(1, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0)});
    tbl.push_back('{I(0, 1, 32'h80, 0, 0, 0, 0, FREE, 0), idl});
    tbl.push_back('{I(0, 1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h1111_2222),
                    O(0, 1, 32'h1111_2222, 0, 1, 0, 32'h80, 0, 0)});
    tbl.push_back('{I(0, 0, 0, 0, 0, 0, 0, FREE, 0), idl});
    // data read withdrawn while BUSY: back to IDLE, a late ACCESS is ignored
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h200, 0, FREE, 0), idl});
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h200, 0, BUSY, 0), O(1, 1, 0, 0, 1, 0, 32'h200, 0, 0)});
    tbl.push_back('{I(0, 0, 0, 0, 0, 32'h200, 0, BUSY, 0), O(1, 1, 0, 0, 0, 0, 32'h200, 0, 0)});
    tbl.push_back('{I(0, 0, 0, 0, 0, 0, 0, ACCESS, 32'h5), idl});
    // ERROR holds the grant without completing
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h300, 0, FREE, 0), idl});
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h300, 0, ERROR, 32'hAAAA), O(1, 1, 0, 0, 1, 0, 32'h300, 0, 0)});
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h300, 0, ACCESS, 32'h1234_5678),
                    O(1, 0, 0, 32'h1234_5678, 1, 0, 32'h300, 0, 0)});
    tbl.push_back('{I(0, 0, 0, 0, 0, 0, 0, FREE, 0), idl});
    // reset during a BUSY data grant: no completion, IDLE afterwards
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h400, 0, FREE, 0), idl});
    tbl.push_back('{I(0, 0, 0, 1, 0, 32'h400, 0, BUSY, 0), O(1, 1, 0, 0, 1, 0, 32'h400, 0, 0)});
    tbl.push_back('{I(1, 0, 0, 1, 0, 32'h400, 0, ACCESS, 32'h9), idl});
    tbl.push_back('{I(0, 0, 0, 0, 0, 32'h400, 0, ACCESS, 32'h9), idl});

    apply(I(1, 0, 0, 0, 0, 0, 0, FREE, 0));
    step();
    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      @(negedge clk);
      act = sample();
      n_tests++;
      if (act !== tbl[k].o) begin
        n_fail++;
        $display("FAIL vec%0d: got %h, want %h", k, act, tbl[k].o);
      end
      step();
    end

    // ---------------- starvation: 4 data completions, then instruction ----------------
    apply(I(0, 1, 32'h44, 1, 0, 32'h500, 0, ACCESS, 32'h77));
    dcnt = 0;
    icnt = 0;
    ild  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.dwait) dcnt++;
      if (!bus.iwait) begin
        icnt++;
        ild = bus.iload;
      end
      step();
      if (icnt != 0) break;
    end
    chk("starve_dcomp", 32'(dcnt), 32'd4);
    chk("starve_icomp", 32'(icnt), 32'd1);
    chk("starve_iload", ild, 32'h77);

    apply(I(0, 0, 0, 0, 0, 0, 0, FREE, 0));
    step();
    @(negedge clk);
    chk("starve_idle_ren", {31'd0, bus.ramREN}, 32'd0);
    step();

    // ---------------- watchdog: stuck BUSY data read ----------------
    apply(I(0, 0, 0, 1, 0, 32'h600, 0, BUSY, 0));
    step();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
      exp_tmo = (k == 8);
      exp_ren = (k <= 8);
`else
      exp_tmo = 1'b0;
      exp_ren = 1'b1;
`endif
      chk($sformatf("tmo_cyc%0d", k), {29'd0, bus.tmo, bus.dwait, bus.ramREN},
          {29'd0, exp_tmo, 1'b1, exp_ren});
      step();
    end

    apply(I(0, 0, 0, 0, 0, 0, 0, FREE, 0));
    step();
    @(negedge clk);
    chk("final_idle", {30'd0, bus.dwait, bus.ramREN}, 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
